// File: rtl/timer_run_controller.sv
// Run/set/pause/alarm sequencer for the seconds/minutes/hours counter bank.
// Produces the 1 s tick, cascaded step strobes and overlay status, all registered.
module timer_run_controller #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic       btn_start_i,
  input  logic       dir_down_i,
  input  logic       sec_zero_i,
  input  logic       min_zero_i,
  input  logic       hr_zero_i,
  input  logic       sec_max_i,
  input  logic       min_max_i,
  output logic       cnt_reset_o,
  output logic       sec_step_o,
  output logic       min_step_o,
  output logic       hr_step_o,
  output logic       cnt_forward_o,
  output logic [1:0] set_field_o,
  output logic       running_o,
  output logic       alarm_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SET_SEC = 3'd1;
  localparam logic [2:0] S_SET_MIN = 3'd2;
  localparam logic [2:0] S_SET_HR  = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_PAUSE   = 3'd5;
  localparam logic [2:0] S_ALARM   = 3'd6;

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALM_MAX = AW'(ALARM_TICKS - 1);

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [AW-1:0] alm_q, alm_d;
  logic          dir_q, dir_d;
  logic          cnt_reset_q, cnt_reset_d;
  logic          sec_step_q, sec_step_d;
  logic          min_step_q, min_step_d;
  logic          hr_step_q, hr_step_d;
  logic          fwd_q, fwd_d;
  logic [1:0]    field_q, field_d;
  logic          run_q, run_d;
  logic          alarm_q, alarm_d;

  logic tick, all_zero, start_ok, any_btn;

  assign tick     = (div_q == DIV_MAX);
  assign all_zero = sec_zero_i & min_zero_i & hr_zero_i;
  // A countdown from 00:00:00 has nothing to count, so start is refused.
  assign start_ok = ~(dir_down_i & all_zero);
  assign any_btn  = btn_mode_i | btn_inc_i | btn_start_i;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    alm_d       = alm_q;
    dir_d       = dir_q;
    cnt_reset_d = 1'b0;
    sec_step_d  = 1'b0;
    min_step_d  = 1'b0;
    hr_step_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (btn_start_i) begin
          if (start_ok) begin
            state_d = S_RUN;
            dir_d   = dir_down_i;
          end
        end else if (btn_mode_i) begin
          state_d = S_SET_SEC;
        end
      end
      S_SET_SEC, S_SET_MIN, S_SET_HR: begin
        if (btn_start_i) begin
          if (start_ok) begin
            state_d = S_RUN;
            dir_d   = dir_down_i;
          end
        end else if (btn_mode_i) begin
          if (state_q == S_SET_HR) begin
            state_d = S_IDLE;
            div_d   = '0;
          end else begin
            state_d = state_q + 3'd1;
          end
        end else if (btn_inc_i) begin
          sec_step_d = (state_q == S_SET_SEC);
          min_step_d = (state_q == S_SET_MIN);
          hr_step_d  = (state_q == S_SET_HR);
        end
      end
      S_RUN: begin
        // Pause wins over a coincident tick: divider holds, no strobes.
        if (btn_start_i) begin
          state_d = S_PAUSE;
        end else begin
          div_d = tick ? '0 : div_q + DW'(1);
          if (tick) begin
            if (dir_q) begin
              if (all_zero) begin
                state_d = S_ALARM;
                alm_d   = '0;
              end else begin
                sec_step_d = 1'b1;
                min_step_d = sec_zero_i;
                hr_step_d  = sec_zero_i & min_zero_i;
              end
            end else begin
              sec_step_d = 1'b1;
              min_step_d = sec_max_i;
              hr_step_d  = sec_max_i & min_max_i;
            end
          end
        end
      end
      S_PAUSE: begin
        if (btn_start_i) begin
          state_d = S_RUN;
        end else if (btn_mode_i) begin
          state_d     = S_IDLE;
          div_d       = '0;
          cnt_reset_d = 1'b1;
        end
      end
      S_ALARM: begin
        div_d = tick ? '0 : div_q + DW'(1);
        if (any_btn) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else if (tick) begin
          if (alm_q == ALM_MAX) begin
            state_d = S_IDLE;
          end else begin
            alm_d = alm_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
      end
    endcase

    fwd_d   = ((state_d == S_RUN) || (state_d == S_PAUSE)) ? ~dir_d : 1'b1;
    field_d = (state_d == S_SET_SEC) ? 2'd1 :
              (state_d == S_SET_MIN) ? 2'd2 :
              (state_d == S_SET_HR)  ? 2'd3 : 2'd0;
    run_d   = (state_d == S_RUN);
    alarm_d = (state_d == S_ALARM);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      alm_q       <= '0;
      dir_q       <= 1'b0;
      cnt_reset_q <= 1'b0;
      sec_step_q  <= 1'b0;
      min_step_q  <= 1'b0;
      hr_step_q   <= 1'b0;
      fwd_q       <= 1'b0;
      field_q     <= 2'd0;
      run_q       <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      alm_q       <= alm_d;
      dir_q       <= dir_d;
      cnt_reset_q <= cnt_reset_d;
      sec_step_q  <= sec_step_d;
      min_step_q  <= min_step_d;
      hr_step_q   <= hr_step_d;
      fwd_q       <= fwd_d;
      field_q     <= field_d;
      run_q       <= run_d;
      alarm_q     <= alarm_d;
    end
  end

  assign cnt_reset_o   = cnt_reset_q;
  assign sec_step_o    = sec_step_q;
  assign min_step_o    = min_step_q;
  assign hr_step_o     = hr_step_q;
  assign cnt_forward_o = fwd_q;
  assign set_field_o   = field_q;
  assign running_o     = run_q;
  assign alarm_o       = alarm_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_timer_run_controller.sv
// Directed scenarios plus random button/flag traffic for timer_run_controller,
// every cycle compared against a spec-level model of the controller.
module tb_timer_run_controller;
  localparam int TD = 4;
  localparam int AT = 2;

  logic clk = 1'b0, reset = 1'b0;
  logic b_mode = 1'b0, b_inc = 1'b0, b_start = 1'b0, dir_down = 1'b0;
  logic sz = 1'b0, mz = 1'b0, hz = 1'b0, smx = 1'b0, mmx = 1'b0;
  logic cnt_reset, sec_step, min_step, hr_step, cnt_forward, running, alarm;
  logic [1:0] set_field;
  logic [2:0] state;

  int n_cmp = 0, n_bad = 0, cycn = 0;
  int n_s = 0, n_m = 0, n_h = 0, n_alm = 0;

  // model: mode number as listed for the FSM, run phase, ticks spent alarming
  int m_st = 0, m_ph = 0, m_al = 0;
  bit m_dn = 1'b0;
  logic e_rst = 0, e_s = 0, e_m = 0, e_h = 0, e_fwd = 0, e_run = 0, e_alm = 0;
  logic [1:0] e_fld = 0;
  logic [2:0] e_st = 0;

  always #5 clk = ~clk;

  timer_run_controller #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
    .clk_i(clk), .reset_i(reset), .btn_mode_i(b_mode), .btn_inc_i(b_inc),
    .btn_start_i(b_start), .dir_down_i(dir_down), .sec_zero_i(sz), .min_zero_i(mz),
    .hr_zero_i(hz), .sec_max_i(smx), .min_max_i(mmx), .cnt_reset_o(cnt_reset),
    .sec_step_o(sec_step), .min_step_o(min_step), .hr_step_o(hr_step),
    .cnt_forward_o(cnt_forward), .set_field_o(set_field), .running_o(running),
    .alarm_o(alarm), .state_o(state)
  );

  function automatic logic [12:0] obs();
    return {cnt_reset, sec_step, min_step, hr_step, cnt_forward, set_field, running, alarm, state};
  endfunction

  function automatic logic [12:0] expv();
    return {e_rst, e_s, e_m, e_h, e_fwd, e_fld, e_run, e_alm, e_st};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic model_edge();
    bit st, md, ic, tick, allz;
    e_rst = 0; e_s = 0; e_m = 0; e_h = 0;
    if (reset) begin
      m_st = 0; m_ph = 0; m_al = 0; m_dn = 0;
      e_fwd = 0; e_fld = 0; e_run = 0; e_alm = 0; e_st = 0;
      return;
    end
    st   = b_start;
    md   = b_mode && !b_start;
    ic   = b_inc && !b_start && !b_mode;
    allz = sz && mz && hz;
    tick = (m_ph == TD - 1);
    if (m_st <= 3) begin
      if (st) begin
        if (!(dir_down && allz)) begin m_st = 4; m_dn = dir_down; end
      end else if (md) begin
        m_st = (m_st == 3) ? 0 : m_st + 1;
      end else if (ic && m_st != 0) begin
        e_s = (m_st == 1); e_m = (m_st == 2); e_h = (m_st == 3);
      end
    end else if (m_st == 4) begin
      if (st) m_st = 5;
      else begin
        m_ph = (m_ph + 1) % TD;
        if (tick) begin
          if (m_dn && allz) begin m_st = 6; m_al = 0; end
          else if (m_dn) begin e_s = 1; e_m = sz; e_h = sz && mz; end
          else begin e_s = 1; e_m = smx; e_h = smx && mmx; end
        end
      end
    end else if (m_st == 5) begin
      if (st) m_st = 4;
      else if (md) begin m_st = 0; m_ph = 0; e_rst = 1; end
    end else begin
      if (b_mode || b_inc || b_start) begin m_st = 0; m_ph = 0; end
      else begin
        m_ph = (m_ph + 1) % TD;
        if (tick) begin
          m_al++;
          if (m_al == AT) begin m_st = 0; m_ph = 0; end
        end
      end
    end
    e_fwd = (m_st == 4 || m_st == 5) ? !m_dn : 1'b1;
    e_fld = (m_st >= 1 && m_st <= 3) ? 2'(m_st) : 2'd0;
    e_run = (m_st == 4);
    e_alm = (m_st == 6);
    e_st  = 3'(m_st);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk($sformatf("cycle%0d", cycn), 32'(obs()), 32'(expv()));
    cycn++;
    n_s += int'(sec_step); n_m += int'(min_step); n_h += int'(hr_step);
    n_alm += int'(alarm);
  endtask

  task automatic clr_cnt();
    n_s = 0; n_m = 0; n_h = 0; n_alm = 0;
  endtask

  initial begin
    int lat, pairs;
    // 1: reset and quiet idle
    reset = 1; cyc(); cyc();
    chk("reset_outputs", 32'(obs()), 32'd0);
    reset = 0; clr_cnt();
    for (int k = 0; k < 10; k++) cyc();
    chk("idle_no_strobes", n_s + n_m + n_h, 0);
    chk("idle_forward", 32'(cnt_forward), 32'd1);

    // 2: count-up cascade into minutes
    dir_down = 0; smx = 1; mmx = 0;
    b_start = 1; cyc(); b_start = 0;
    chk("up_running", 32'(running), 32'd1);
    lat = -1; pairs = 0; clr_cnt();
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (sec_step && lat < 0) lat = k;
      if (sec_step && min_step && !hr_step) pairs++;
    end
    chk("up_first_latency", lat, 4);
    chk("up_sec_min_pairs", pairs, 4);
    chk("up_sec_total", n_s, 4);
    chk("up_forward", 32'(cnt_forward), 32'd1);
    b_start = 1; cyc(); b_start = 0;
    chk("pause_state", 32'(state), 32'd5);
    b_mode = 1; cyc(); b_mode = 0;
    chk("pause_mode_clear", 32'(cnt_reset), 32'd1);
    chk("pause_mode_idle", 32'(state), 32'd0);
    smx = 0;

    // 3: countdown, borrow into minutes, then expire into alarm
    dir_down = 1; sz = 1; mz = 0; hz = 0;
    b_start = 1; cyc(); b_start = 0;
    chk("down_forward", 32'(cnt_forward), 32'd0);
    for (int k = 1; k <= 4; k++) cyc();
    chk("down_cascade", 32'({sec_step, min_step, hr_step}), 32'b110);
    mz = 1; hz = 1; clr_cnt();
    for (int k = 5; k <= 20; k++) cyc();
    chk("alarm_cycles", n_alm, 8);
    chk("alarm_no_strobes", n_s + n_m + n_h, 0);
    chk("alarm_exit_idle", 32'(state), 32'd0);
    b_start = 1; cyc(); b_start = 0;
    chk("zero_start_refused", 32'(state), 32'd0);

    // 4: set mode field stepping
    dir_down = 0; sz = 0; mz = 0; hz = 0;
    b_mode = 1; cyc(); b_mode = 0;
    chk("set_sec_field", 32'(set_field), 32'd1);
    clr_cnt();
    for (int k = 0; k < 3; k++) begin b_inc = 1; cyc(); b_inc = 0; cyc(); end
    chk("set_sec_steps", n_s, 3);
    chk("set_sec_only", n_m + n_h, 0);
    b_mode = 1; cyc(); b_mode = 0;
    chk("set_min_field", 32'(set_field), 32'd2);
    clr_cnt();
    b_inc = 1; b_start = 0; cyc(); b_inc = 0; cyc();
    chk("set_min_step", n_m, 1);
    chk("set_min_only", n_s + n_h, 0);
    b_mode = 1; cyc(); cyc(); b_mode = 0;
    chk("set_exit_field", 32'(set_field), 32'd0);
    chk("set_exit_idle", 32'(state), 32'd0);

    // 5: pause keeps divider phase
    b_start = 1; cyc(); b_start = 0;
    cyc();
    b_start = 1; cyc(); b_start = 0;
    chk("pause_at_div1", 32'(state), 32'd5);
    clr_cnt();
    for (int k = 0; k < 20; k++) cyc();
    chk("pause_no_strobes", n_s + n_m + n_h, 0);
    b_start = 1; cyc(); b_start = 0;
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (sec_step && lat < 0) lat = k;
    end
    chk("resume_latency", lat, 3);

    // 6: reset on tick cycle, then start coinciding with tick
    for (int g = 0; g < 2 * TD && m_ph != TD - 1; g++) cyc();
    reset = 1; cyc(); reset = 0;
    chk("reset_tick_outputs", 32'(obs()), 32'd0);
    cyc();
    chk("reset_tick_no_strobe", 32'({sec_step, min_step, hr_step}), 32'd0);
    b_start = 1; cyc(); b_start = 0;
    for (int g = 0; g < 2 * TD && m_ph != TD - 1; g++) cyc();
    b_start = 1; cyc(); b_start = 0;
    chk("start_tick_pause", 32'(state), 32'd5);
    chk("start_tick_no_strobe", 32'({sec_step, min_step, hr_step}), 32'd0);
    cyc();
    chk("start_tick_still_quiet", 32'({sec_step, min_step, hr_step}), 32'd0);

    // 7: random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      b_start = ($urandom_range(0, 15) == 0);
      b_mode  = ($urandom_range(0, 9) == 0);
      b_inc   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) dir_down = $urandom_range(0, 1) != 0;
      sz  = ($urandom_range(0, 2) == 0);
      mz  = ($urandom_range(0, 1) == 0);
      hz  = ($urandom_range(0, 1) == 0);
      smx = ($urandom_range(0, 2) == 0);
      mmx = ($urandom_range(0, 1) == 0);
      cyc();
    end
    reset = 0; b_start = 0; b_mode = 0; b_inc = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
